lf_sub16_pipe: RTL and testbench
================================

Name: lf_sub16_pipe

Overview:
- Pipelined 16-bit unsigned/two's-complement subtractor: the inverse operation of the team's 16-bit Ladner-Fischer adder.
- Computes X - Y as X + ~Y + 1 through the same Ladner-Fischer prefix structure, with Cin tied to 1.
- Sits between producer and consumer logic in the datapath library and uses a valid/ready handshake on both sides.
- Two register stages, so it can close timing where the single-cycle combinational adder cannot.

Parameters:
- WIDTH, 16, operand width. Only 16 is supported; any other value must cause an elaboration error.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  X/Y present and valid.
- in_ready  out  1  block accepts X/Y this cycle.
- X  in  16  minuend.
- Y  in  16  subtrahend.
- out_valid  out  1  S/ovf valid.
- out_ready  in  1  consumer accepts S/ovf this cycle.
- S  out  17  S[15:0] = (X - Y) mod 2^16; S[16] = borrow (1 iff X < Y unsigned).
- ovf  out  1  signed overflow: X[15] != Y[15] and S[15] != X[15].

Behaviour:
- Reset (async assert, sync release):
  - v1 = v2 = 0, out_valid = 0.
  - S = 17'h0, ovf = 0.
  - All stage data registers cleared.
  - A reset mid-operation discards any in-flight operations.
- Stage 1 (s1), loaded when in_valid && in_ready:
  - per-bit g = X & ~Y, p = X ^ ~Y;
  - bit0 group generate folded with Cin = 1;
  - prefix levels 1-2 (span 1, span 2);
  - registers the level-2 group g/p, the raw per-bit p, and X[15], Y[15].
  - v1 <= 1 on load; otherwise v1 <= 0 when s1 drains into s2.
- Stage 2 (s2), loaded when v1 && adv2:
  - prefix levels 3-4 (span 4, span 8), Ladner-Fischer fan-out pattern;
  - odd-position fix-up, carry into each bit, sum = p ^ carry;
  - Cout = carry out of bit 15; S[16] = ~Cout;
  - ovf computed as above.
  - S/ovf registered; v2 = out_valid.
- Flow control:
  - adv2 = !v2 || out_ready;
  - adv1 = !v1 || adv2;
  - in_ready = adv1.
  - This is a combinational out_ready -> in_ready path, and it is accepted.
  - Bubbles collapse: an empty s2 loads from s1 even while out_ready = 0.
- Latency: 2 cycles from an accepted input to out_valid = 1. Throughput 1/cycle while out_ready = 1.
- Stall: while out_valid && !out_ready, S/ovf/out_valid hold constant. s1 holds if it is full. At most 2 operations are in flight.
- Ordering: strictly FIFO, with no reordering or dropping.
- Simultaneous s2 consume and s1 advance in one cycle: s2 takes the s1 data and s1 takes the new input, with no bubble.
- Arithmetic boundaries:
  - X = Y gives S = 17'h00000.
  - 0 - 1 gives S[15:0] = 16'hFFFF, S[16] = 1.
  - Wrap-around is mod 2^16; no saturation.
- in_valid = 0 with in_ready = 1: nothing loaded; X/Y are don't-care.

Test Plan:
- Reset, then X = 16'h1234, Y = 16'h0234, in_valid one cycle, out_ready = 1 -> out_valid two cycles later; S = 17'h01000, ovf = 0.
- X = 16'h0000, Y = 16'h0001 -> S = 17'h1FFFF (borrow = 1), ovf = 0. Then X = 16'h8000, Y = 16'h0001 -> S = 17'h07FFF, ovf = 1.
- Back-to-back stream of 100 random pairs with out_ready = 1 -> one result per cycle after a 2-cycle fill; every S matches {X < Y, X - Y} in order.
- out_ready = 0 for 5 cycles while feeding 3 operations:
  - in_ready drops after 2 are accepted; out_valid/S stay stable;
  - after release, all 3 results emerge in order with no loss or duplication.
- Random in_valid and out_ready (50% each) over 10k operations, compared against a scoreboard -> exact match, no handshake violations.
- Assert rst_n with 2 operations in flight -> out_valid = 0 and S = 0 immediately (async). After release, a new op X = 16'hFFFF, Y = 16'hFFFF -> S = 17'h00000, with no stale results emitted.

Source files
------------

// File: rtl/lf_sub16_pipe.sv
// rtl/lf_sub16_pipe.sv - two-stage Ladner-Fischer subtractor (X - Y) with valid/ready handshake
module lf_sub16_pipe #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] X,
    input  logic [WIDTH-1:0] Y,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH:0]   S,
    output logic             ovf
);

    generate
        if (WIDTH != 16) begin : g_width_check
            $error("lf_sub16_pipe: only WIDTH = 16 is supported");
        end
    endgenerate

    // Flow control
    logic v1_q, v1_d;
    logic v2_q, v2_d;
    logic adv1, adv2, load1, load2;

    assign adv2     = !v2_q || out_ready;
    assign adv1     = !v1_q || adv2;
    assign in_ready = adv1;
    assign load1    = in_valid && adv1;
    assign load2    = v1_q && adv2;

    always_comb begin
        v1_d = v1_q;
        v2_d = v2_q;
        if (load1) begin
            v1_d = 1'b1;
        end else if (adv2) begin
            v1_d = 1'b0;
        end
        if (adv2) begin
            v2_d = v1_q;
        end
    end

    // Stage 1: bit generate/propagate of X + ~Y, carry-in folded into bit 0, levels 1-2
    logic [WIDTH-1:0] g_l0, p_l0, p_bit;
    logic [WIDTH-1:0] g_l1, p_l1;
    logic [WIDTH-1:0] g_l2, p_l2;

    assign p_bit = X ^ ~Y;

    generate
        for (genvar i = 0; i < WIDTH; i++) begin : g_stage1
            if (i == 0) begin : g_bit0
                assign g_l0[i] = (X[i] & ~Y[i]) | p_bit[i];
                assign p_l0[i] = 1'b0;
            end else begin : g_bitn
                assign g_l0[i] = X[i] & ~Y[i];
                assign p_l0[i] = p_bit[i];
            end

            if (i % 2 == 1) begin : g_lvl1
                assign g_l1[i] = g_l0[i] | (p_l0[i] & g_l0[i-1]);
                assign p_l1[i] = p_l0[i] & p_l0[i-1];
            end else begin : g_lvl1_pass
                assign g_l1[i] = g_l0[i];
                assign p_l1[i] = p_l0[i];
            end

            if (i % 4 == 3) begin : g_lvl2
                assign g_l2[i] = g_l1[i] | (p_l1[i] & g_l1[i-2]);
                assign p_l2[i] = p_l1[i] & p_l1[i-2];
            end else begin : g_lvl2_pass
                assign g_l2[i] = g_l1[i];
                assign p_l2[i] = p_l1[i];
            end
        end
    endgenerate

    logic [WIDTH-1:0] s1_g_q, s1_p_q, s1_praw_q;
    logic             s1_x15_q, s1_y15_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1_q      <= 1'b0;
            s1_g_q    <= '0;
            s1_p_q    <= '0;
            s1_praw_q <= '0;
            s1_x15_q  <= 1'b0;
            s1_y15_q  <= 1'b0;
        end else begin
            v1_q <= v1_d;
            if (load1) begin
                s1_g_q    <= g_l2;
                s1_p_q    <= p_l2;
                s1_praw_q <= p_bit;
                s1_x15_q  <= X[WIDTH-1];
                s1_y15_q  <= Y[WIDTH-1];
            end
        end
    end

    // Stage 2: levels 3-4 on odd positions only, then even positions fixed up from their odd neighbour
    logic [WIDTH-1:0] g_l3, p_l3, g_l4, g_fix, carry, sum_d;
    logic [WIDTH:0]   s_d;
    logic             ovf_d;

    generate
        for (genvar i = 0; i < WIDTH; i++) begin : g_stage2
            if ((i % 2 == 1) && ((i / 4) % 2 == 1)) begin : g_lvl3
                assign g_l3[i] = s1_g_q[i] | (s1_p_q[i] & s1_g_q[(i/4)*4-1]);
                assign p_l3[i] = s1_p_q[i] & s1_p_q[(i/4)*4-1];
            end else begin : g_lvl3_pass
                assign g_l3[i] = s1_g_q[i];
                assign p_l3[i] = s1_p_q[i];
            end

            if ((i % 2 == 1) && (i >= 8)) begin : g_lvl4
                assign g_l4[i] = g_l3[i] | (p_l3[i] & g_l3[7]);
            end else begin : g_lvl4_pass
                assign g_l4[i] = g_l3[i];
            end

            if ((i % 2 == 0) && (i > 0)) begin : g_fixup
                assign g_fix[i] = g_l4[i] | (s1_p_q[i] & g_l4[i-1]);
            end else begin : g_fixup_pass
                assign g_fix[i] = g_l4[i];
            end

            if (i == 0) begin : g_cin
                assign carry[i] = 1'b1;
            end else begin : g_cprop
                assign carry[i] = g_fix[i-1];
            end
        end
    endgenerate

    logic unused_p_l3;
    assign unused_p_l3 = ^p_l3;

    assign sum_d = s1_praw_q ^ carry;
    assign s_d   = {~g_fix[WIDTH-1], sum_d};
    assign ovf_d = (s1_x15_q != s1_y15_q) && (sum_d[WIDTH-1] != s1_x15_q);

    logic [WIDTH:0] s_q;
    logic           ovf_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v2_q  <= 1'b0;
            s_q   <= '0;
            ovf_q <= 1'b0;
        end else begin
            v2_q <= v2_d;
            if (load2) begin
                s_q   <= s_d;
                ovf_q <= ovf_d;
            end
        end
    end

    assign out_valid = v2_q;
    assign S         = s_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_lf_sub16_pipe.sv
// tb/tb_lf_sub16_pipe.sv - randomized scoreboard bench for lf_sub16_pipe
module tb_lf_sub16_pipe;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] X;
    logic [15:0] Y;
    logic        out_valid;
    logic        out_ready;
    logic [16:0] S;
    logic        ovf;

    lf_sub16_pipe #(.WIDTH(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .X         (X),
        .Y         (Y),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .S         (S),
        .ovf       (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_pass   = 0;
    int          cyc      = 0;
    int          n_out    = 0;
    int          first_out;
    int          last_out;
    logic [17:0] exp_q[$];
    logic        hold_pending = 1'b0;
    logic [16:0] held_s;
    logic        held_ovf;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        if (obs === expv) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
    endtask

    // Reference: {ovf, borrow, difference} straight from integer arithmetic
    function automatic logic [17:0] model(input logic [15:0] x, input logic [15:0] y);
        int          d;
        logic [15:0] diff;
        logic        ov;
        diff = 16'(x - y);
        d    = int'($signed(x)) - int'($signed(y));
        ov   = (d > 32767) || (d < -32768);
        return {ov, (x < y), diff};
    endfunction

    // One cycle: inputs set at negedge, outputs sampled 1 time unit later, then advance
    task automatic step(input logic iv, input logic [15:0] x, input logic [15:0] y,
                        input logic ordy, output logic acc);
        logic [17:0] e;
        in_valid  = iv;
        X         = x;
        Y         = y;
        out_ready = ordy;
        #1;
        if (hold_pending) begin
            check_eq("hold_valid", out_valid, 1);
            check_eq("hold_S", S, held_s);
            check_eq("hold_ovf", ovf, held_ovf);
        end
        if (out_valid && out_ready) begin
            n_out++;
            if (first_out < 0) first_out = cyc;
            last_out = cyc;
            if (exp_q.size() == 0) begin
                check_eq("spurious_out", out_valid, 0);
            end else begin
                e = exp_q.pop_front();
                check_eq("sb_S", S, e[16:0]);
                check_eq("sb_ovf", ovf, e[17]);
            end
        end
        acc = iv && in_ready;
        if (acc) exp_q.push_back(model(x, y));
        hold_pending = out_valid && !out_ready;
        held_s       = S;
        held_ovf     = ovf;
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    task automatic directed(input string tag, input logic [15:0] x, input logic [15:0] y,
                            input logic [16:0] exp_s, input logic exp_ovf);
        logic acc;
        step(1'b1, x, y, 1'b1, acc);
        check_eq({tag, "_acc"}, acc, 1);
        #1;
        check_eq({tag, "_lat1"}, out_valid, 0);
        step(1'b0, 16'h0, 16'h0, 1'b1, acc);
        #1;
        check_eq({tag, "_valid"}, out_valid, 1);
        check_eq({tag, "_S"}, S, exp_s);
        check_eq({tag, "_ovf"}, ovf, exp_ovf);
        step(1'b0, 16'h0, 16'h0, 1'b1, acc);
    endtask

    task automatic drain(input string tag);
        logic acc;
        int   n;
        n = 0;
        while (exp_q.size() != 0 && n < 20) begin
            step(1'b0, 16'h0, 16'h0, 1'b1, acc);
            n++;
        end
        repeat (3) step(1'b0, 16'h0, 16'h0, 1'b1, acc);
        check_eq({tag, "_drained"}, exp_q.size(), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic        acc;
        int          c0, n0, k, acc_cnt, guard;
        logic [15:0] ox[3];
        logic [15:0] oy[3];

        first_out = -1;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        X         = 16'h0;
        Y         = 16'h0;
        repeat (3) @(negedge clk);
        #1;
        check_eq("rst_out_valid", out_valid, 0);
        check_eq("rst_S", S, 17'h0);
        check_eq("rst_ovf", ovf, 0);
        check_eq("rst_in_ready", in_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;

        directed("d1234", 16'h1234, 16'h0234, 17'h01000, 1'b0);
        directed("d0m1", 16'h0000, 16'h0001, 17'h1FFFF, 1'b0);
        directed("d8000", 16'h8000, 16'h0001, 17'h07FFF, 1'b1);
        directed("d7fff", 16'h7FFF, 16'hFFFF, 17'h18000, 1'b1);
        directed("deq", 16'hA5A5, 16'hA5A5, 17'h00000, 1'b0);

        // Back-to-back stream
        first_out = -1;
        n0        = n_out;
        c0        = cyc;
        acc_cnt   = 0;
        for (int i = 0; i < 100; i++) begin
            step(1'b1, 16'($urandom), 16'($urandom), 1'b1, acc);
            if (acc) acc_cnt++;
        end
        drain("stream");
        check_eq("stream_accepted", acc_cnt, 100);
        check_eq("stream_count", n_out - n0, 100);
        check_eq("stream_latency", first_out - c0, 2);
        check_eq("stream_gapless", last_out - first_out, 99);

        // Stall with three queued operations
        for (int i = 0; i < 3; i++) begin
            ox[i] = 16'($urandom);
            oy[i] = 16'($urandom);
        end
        n0 = n_out;
        k  = 0;
        for (int i = 0; i < 5; i++) begin
            step(1'b1, ox[k], oy[k], 1'b0, acc);
            if (acc) k++;
        end
        check_eq("stall_accepted", k, 2);
        in_valid  = 1'b1;
        X         = ox[k];
        Y         = oy[k];
        out_ready = 1'b0;
        #1;
        check_eq("stall_in_ready", in_ready, 0);
        check_eq("stall_out_valid", out_valid, 1);
        guard = 0;
        while (k < 3 && guard < 10) begin
            step(1'b1, ox[k], oy[k], 1'b1, acc);
            if (acc) k++;
            guard++;
        end
        check_eq("stall_all_in", k, 3);
        drain("stall");
        check_eq("stall_count", n_out - n0, 3);

        // Random handshake on both sides
        acc_cnt = 0;
        guard   = 0;
        while (acc_cnt < 10000 && guard < 60000) begin
            step(1'($urandom_range(0, 1)), 16'($urandom), 16'($urandom),
                 1'($urandom_range(0, 1)), acc);
            if (acc) acc_cnt++;
            guard++;
        end
        check_eq("rand_accepted", acc_cnt, 10000);
        drain("rand");

        // Asynchronous reset with two operations in flight
        step(1'b1, 16'h1111, 16'h0001, 1'b0, acc);
        step(1'b1, 16'h2222, 16'h0002, 1'b0, acc);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("arst_out_valid", out_valid, 0);
        check_eq("arst_S", S, 17'h0);
        check_eq("arst_ovf", ovf, 0);
        check_eq("arst_in_ready", in_ready, 1);
        exp_q.delete();
        hold_pending = 1'b0;
        in_valid     = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        directed("post_rst", 16'hFFFF, 16'hFFFF, 17'h00000, 1'b0);
        drain("post_rst");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
